// File: rtl/cam_pkg.sv
// Shared types and sizing for the password CAM and its search-side reader.
// The match vector width helper keeps the reader and the CAM array in agreement.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } cam_state_e;

  localparam int CAM_DATA_WIDTH = 4;
  localparam int CAM_ADDR_WIDTH = 4;

  function automatic int cam_vec_width(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/cam_match_reader_if.sv
// Key request, CAM search port and result stream of the CAM match reader.
// CAM_RD_COUNT_EN adds res_count (population count of the captured match vector).
interface cam_match_reader_if
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
);
  localparam int VW = cam_vec_width(ADDR_WIDTH);

  logic                  key_valid;
  logic                  key_ready;
  logic [DATA_WIDTH-1:0] key_data;
  logic [DATA_WIDTH-1:0] cam_key;
  logic [VW-1:0]         cam_match;
  logic                  res_valid;
  logic                  res_ready;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic                  res_last;
  logic                  res_miss;
  logic                  busy;
`ifdef CAM_RD_COUNT_EN
  logic [ADDR_WIDTH:0]   res_count;

  modport slave (
    input  key_valid, key_data, cam_match, res_ready,
    output key_ready, cam_key, res_valid, res_addr, res_last, res_miss, busy, res_count
  );
  modport master (
    output key_valid, key_data, cam_match, res_ready,
    input  key_ready, cam_key, res_valid, res_addr, res_last, res_miss, busy, res_count
  );
`else
  modport slave (
    input  key_valid, key_data, cam_match, res_ready,
    output key_ready, cam_key, res_valid, res_addr, res_last, res_miss, busy
  );
  modport master (
    output key_valid, key_data, cam_match, res_ready,
    input  key_ready, cam_key, res_valid, res_addr, res_last, res_miss, busy
  );
`endif

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit encoder over the pending match vector; purely combinational.
// o_single flags exactly one bit set, which marks the final result beat.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
  input  logic [cam_vec_width(ADDR_WIDTH)-1:0] i_vec,
  output logic [ADDR_WIDTH-1:0]                o_idx,
  output logic                                 o_any,
  output logic                                 o_single
);
  localparam int VW = cam_vec_width(ADDR_WIDTH);

  // Scan downward so the lowest set bit is the last assignment to win.
  always_comb begin
    o_idx = '0;
    for (int i = VW - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ADDR_WIDTH'(i);
    end
  end

  assign o_any    = |i_vec;
  assign o_single = o_any && ((i_vec & (i_vec - VW'(1))) == '0);

endmodule

// File: rtl/cam_match_reader.sv
// CAM search controller: key -> cam_key, capture match vector MATCH_LAT edges later, stream hits ascending.
// One beat per cycle under res_ready; beats hold while stalled. CAM_RD_COUNT_EN adds res_count.
module cam_match_reader
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int MATCH_LAT  = 1
) (
  input logic               clk,
  input logic               rst_n,
  cam_match_reader_if.slave bus
);
  localparam int VW = cam_vec_width(ADDR_WIDTH);
  localparam int CW = (MATCH_LAT < 2) ? 1 : $clog2(MATCH_LAT + 1);

  cam_state_e            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_cam_key;
  logic [CW-1:0]         r_cnt;
  logic [VW-1:0]         r_pend;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_any, w_single, w_capture, w_xfer, w_last;

  cam_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_enc (
    .i_vec   (r_pend),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_single(w_single)
  );

  // Capture on the edge where the counter would reach zero, i.e. MATCH_LAT edges after acceptance.
  assign w_capture = (r_state == LOOKUP) && (r_cnt <= CW'(1));
  assign w_last    = !w_any || w_single;
  assign w_xfer    = (r_state == EMIT) && bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.key_valid) w_state_nxt = LOOKUP;
      LOOKUP:  if (w_capture) w_state_nxt = EMIT;
      EMIT:    if (w_xfer && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_key <= '0;
      r_cnt     <= '0;
      r_pend    <= '0;
    end else begin
      if (r_state == IDLE && bus.key_valid) begin
        r_cam_key <= bus.key_data;
        r_cnt     <= CW'(MATCH_LAT);
      end
      if (r_state == LOOKUP) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_capture) r_pend <= bus.cam_match;
      end
      if (w_xfer) r_pend <= r_pend & (r_pend - VW'(1));
    end
  end

`ifdef CAM_RD_COUNT_EN
  logic [ADDR_WIDTH:0] r_count;

  function automatic logic [ADDR_WIDTH:0] popcnt(input logic [VW-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < VW; i++) c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_count <= '0;
    else if (w_capture) r_count <= popcnt(bus.cam_match);
  end

  assign bus.res_count = r_count;
`endif

  assign bus.cam_key   = r_cam_key;
  assign bus.key_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.res_valid = (r_state == EMIT);
  assign bus.res_addr  = w_any ? w_idx : '0;
  assign bus.res_last  = (r_state == EMIT) && w_last;
  assign bus.res_miss  = (r_state == EMIT) && !w_any;

endmodule
